// File: rtl/snn_pkg.sv
// Shared SNN definitions: default geometry for the spike path, the
// spike-time and spike-vector types, and the encoder state encoding.
package snn_pkg;

  localparam int NUM_SPIKES  = 8;
  localparam int TIME_PERIOD = 8;
  // One extra bit so TIME_PERIOD itself is representable as "no spike".
  localparam int TBITS       = $clog2(TIME_PERIOD) + 1;

  typedef logic [TBITS-1:0]      spike_time_t;
  typedef logic [NUM_SPIKES-1:0] spike_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/spike_encoder_wave_timer.sv
// wave_timer: tick and gap counters for the spike encoder.
//   clk, rst_l  : clock, synchronous active-low reset
//   run, gap    : encoder is in RUN / GAP this cycle
//   tick        : tick within the wave, 0 outside RUN
//   wave_start  : RUN and tick == 0
//   wave_done   : RUN and tick == TIME_PERIOD-1
//   gap_end     : last quiet cycle of the gap
module wave_timer
  import snn_pkg::*;
#(
  parameter int TIME_PERIOD = snn_pkg::TIME_PERIOD,
  parameter int GAP_CYCLES  = 2,
  parameter int TBITS       = $clog2(TIME_PERIOD) + 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             run,
  input  logic             gap,
  output logic [TBITS-1:0] tick,
  output logic             wave_start,
  output logic             wave_done,
  output logic             gap_end
);

  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [TBITS-1:0] TICK_LAST = TBITS'(TIME_PERIOD - 1);
  localparam logic [GW-1:0]    GCNT_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [GW-1:0] gcnt;

  // tick only advances inside RUN and wraps to 0 at the last tick; every
  // exit from RUN (to GAP, IDLE or a reload) therefore sees tick == 0.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      tick <= '0;
      gcnt <= '0;
    end else begin
      tick <= (run && (tick != TICK_LAST)) ? tick + 1'b1 : '0;
      gcnt <= gap ? gcnt + 1'b1 : '0;
    end
  end

  assign wave_start = run && (tick == '0);
  assign wave_done  = run && (tick == TICK_LAST);
  assign gap_end    = gap && (GAP_CYCLES > 0) && (gcnt == GCNT_LAST);

endmodule

// File: rtl/spike_encoder.sv
// spike_encoder: temporal-coding front end. Accepts a frame of per-input
// spike times over valid/ready into a one-deep pending buffer, then replays
// it as a wave of TIME_PERIOD ticks, pulsing spikes_out[i] at tick
// in_times[i]. A time >= TIME_PERIOD never spikes.
//   clk, rst_l  : clock, synchronous active-low reset
//   in_valid    : frame offered on in_times
//   in_ready    : pending buffer empty
//   in_times    : packed per-input spike times
//   spikes_out  : spike pulses to the neuron
//   tick        : current tick, 0 outside RUN
//   wave_start  : RUN cycle with tick == 0
//   wave_done   : RUN cycle with tick == TIME_PERIOD-1
//   busy        : state is not IDLE
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES  = snn_pkg::NUM_SPIKES,
  parameter int TIME_PERIOD = snn_pkg::TIME_PERIOD,
  parameter int TBITS       = $clog2(TIME_PERIOD) + 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_SPIKES-1:0][TBITS-1:0] in_times,
  output logic [NUM_SPIKES-1:0]            spikes_out,
  output logic [TBITS-1:0]                 tick,
  output logic                             wave_start,
  output logic                             wave_done,
  output logic                             busy
);

  enc_state_t state, state_nx;

  logic [NUM_SPIKES-1:0][TBITS-1:0] pend_times;
  logic [NUM_SPIKES-1:0][TBITS-1:0] act_time;
  logic                             pend_full;

  logic run, gap, gap_end, load;

  wave_timer #(
    .TIME_PERIOD (TIME_PERIOD),
    .GAP_CYCLES  (GAP_CYCLES),
    .TBITS       (TBITS)
  ) u_timer (
    .clk        (clk),
    .rst_l      (rst_l),
    .run        (run),
    .gap        (gap),
    .tick       (tick),
    .wave_start (wave_start),
    .wave_done  (wave_done),
    .gap_end    (gap_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state. load marks every edge that moves the pending frame into
  // the active set; it always requires pend_full, so it never overlaps an
  // accept.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          state_nx = RUN;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (wave_done) begin
          if (GAP_CYCLES > 0) begin
            state_nx = GAP;
          end else if (pend_full) begin
            state_nx = RUN;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_end) begin
          if (pend_full) begin
            state_nx = RUN;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    run  = (state == RUN);
    gap  = (state == GAP);
    busy = (state != IDLE);
  end

  assign in_ready = !pend_full;

  // Pending and active frame buffers.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      pend_full  <= 1'b0;
      pend_times <= '0;
      act_time   <= '0;
    end else begin
      if (load) begin
        act_time  <= pend_times;
        pend_full <= 1'b0;
      end else if (in_valid && !pend_full) begin
        pend_times <= in_times;
        pend_full  <= 1'b1;
      end
    end
  end

  // Per-input comparators. tick never exceeds TIME_PERIOD-1, so any
  // out-of-range time simply never matches.
  for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_cmp
    assign spikes_out[i] = run && (act_time[i] == tick);
  end

endmodule

// File: tb/tb_spike_encoder.sv
module tb_spike_encoder;

  localparam int NS = 8;
  localparam int TB = 4;

  logic                  clk = 1'b0;
  logic                  rst_l;
  logic                  in_valid;
  logic                  in_ready;
  logic [NS-1:0][TB-1:0] in_times;
  logic [NS-1:0]         spikes_out;
  logic [TB-1:0]         tick;
  logic                  wave_start;
  logic                  wave_done;
  logic                  busy;

  int ncomp = 0;
  int nfail = 0;

  spike_encoder #(
    .NUM_SPIKES  (8),
    .TIME_PERIOD (8),
    .GAP_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_times   (in_times),
    .spikes_out (spikes_out),
    .tick       (tick),
    .wave_start (wave_start),
    .wave_done  (wave_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one RUN cycle against the expected tick and spike vector.
  task automatic chk_run(input string tag, input int t, input logic [7:0] exp_sp);
    chk({tag, " tick"},  32'(tick), 32'(t));
    chk({tag, " spikes"}, 32'(spikes_out), 32'(exp_sp));
    chk({tag, " start"}, 32'(wave_start), 32'(t == 0));
    chk({tag, " done"},  32'(wave_done), 32'(t == 7));
    chk({tag, " busy"},  32'(busy), 32'd1);
  endtask

  task automatic chk_gap(input string tag);
    chk({tag, " gap spikes"}, 32'(spikes_out), 32'd0);
    chk({tag, " gap tick"},   32'(tick), 32'd0);
    chk({tag, " gap busy"},   32'(busy), 32'd1);
  endtask

  task automatic offer(input logic [NS-1:0][TB-1:0] t);
    in_times = t;
    in_valid = 1'b1;
    step();                 // accept edge E0
    in_valid = 1'b0;
    in_times = '0;
    step();                 // E1: RUN, tick 0
  endtask

  logic [NS-1:0][TB-1:0] ramp, rev, all3, all8;
  logic [7:0] exp_sp;

  initial begin
    for (int i = 0; i < NS; i++) begin
      ramp[i] = TB'(i);
      rev[i]  = TB'(7 - i);
      all3[i] = 4'd3;
      all8[i] = 4'd8;
    end

    // 1: reset and idle
    rst_l = 1'b0; in_valid = 1'b0; in_times = '0;
    step(); step();
    rst_l = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("idle ready", 32'(in_ready), 32'd1);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle spikes", 32'(spikes_out), 32'd0);
      chk("idle tick", 32'(tick), 32'd0);
    end

    // 2: walking one-hot
    in_times = ramp; in_valid = 1'b1;
    step();
    chk("t2 accept ready", 32'(in_ready), 32'd0);
    chk("t2 accept busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    step();
    for (int t = 0; t < 8; t++) begin
      exp_sp = 8'h01 << t;
      chk_run("t2", t, exp_sp);
      chk("t2 ready", 32'(in_ready), 32'd1);
      step();
    end
    chk_gap("t2 g0"); step();
    chk_gap("t2 g1"); step();
    chk("t2 idle busy", 32'(busy), 32'd0);

    // 3: all at tick 3
    offer(all3);
    for (int t = 0; t < 8; t++) begin
      exp_sp = (t == 3) ? 8'hFF : 8'h00;
      chk_run("t3", t, exp_sp);
      step();
    end
    chk_gap("t3 g0"); step(); step();
    chk("t3 idle busy", 32'(busy), 32'd0);

    // 4: out-of-range times never spike
    offer(all8);
    for (int t = 0; t < 8; t++) begin
      chk_run("t4", t, 8'h00);
      step();
    end
    chk_gap("t4 g0"); step();
    chk("t4 no restart", 32'(wave_start), 32'd0);
    step();
    chk("t4 idle busy", 32'(busy), 32'd0);

    // 5: frame B queued during wave A
    offer(ramp);
    step(); step();                           // tick 2
    chk("t5 tick2", 32'(tick), 32'd2);
    chk("t5 ready before B", 32'(in_ready), 32'd1);
    in_times = rev; in_valid = 1'b1;
    step();                                   // B accepted, tick 3
    in_valid = 1'b0; in_times = '0;
    for (int t = 3; t < 8; t++) begin
      exp_sp = 8'h01 << t;
      chk_run("t5 A", t, exp_sp);
      chk("t5 ready pend", 32'(in_ready), 32'd0);
      step();
    end
    chk_gap("t5 g0");
    chk("t5 g0 ready", 32'(in_ready), 32'd0);
    step();
    chk_gap("t5 g1");
    chk("t5 g1 ready", 32'(in_ready), 32'd0);
    step();                                   // 3 cycles after A's done
    for (int t = 0; t < 8; t++) begin
      exp_sp = 8'h80 >> t;
      chk_run("t5 B", t, exp_sp);
      chk("t5 B ready", 32'(in_ready), 32'd1);
      step();
    end
    step(); step();
    chk("t5 idle busy", 32'(busy), 32'd0);

    // 6: reset mid-wave with B pending
    offer(ramp);
    step();                                   // tick 1
    in_times = rev; in_valid = 1'b1;
    step();                                   // B accepted, tick 2
    in_valid = 1'b0; in_times = '0;
    chk("t6 pend ready", 32'(in_ready), 32'd0);
    step(); step();                           // tick 4
    chk("t6 tick4", 32'(tick), 32'd4);
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
    chk("t6 rst spikes", 32'(spikes_out), 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst ready", 32'(in_ready), 32'd1);
    chk("t6 rst tick", 32'(tick), 32'd0);
    for (int c = 0; c < 14; c++) begin
      step();
      chk("t6 after busy", 32'(busy), 32'd0);
      chk("t6 after done", 32'(wave_done), 32'd0);
      chk("t6 after spikes", 32'(spikes_out), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
